// File: rtl/rx_tx_pkg.sv
// Shared constants and types for the per-port RX/TX MAC pair.
// The CRC constants serve both the TX FCS generator and the RX FCS checker.
package rx_tx_pkg;

  localparam int          GMII_DATA_WIDTH = 8;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam int          PREAMBLE_LEN    = 7;

  localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_ABORT,
    ST_IFG
  } tx_state_t;

endpackage

// File: rtl/crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32, purely combinational.
// The unrolled chain shifts one bit per stage, LSB first.
module crc32_byte
  import rx_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [8:0][31:0] stage;

  assign stage[0] = crc_in ^ {24'h000000, data};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      assign stage[gi+1] = stage[gi][0] ? ({1'b0, stage[gi][31:1]} ^ CRC32_POLY)
                                        : {1'b0, stage[gi][31:1]};
    end
  endgenerate

  assign crc_out = stage[8];

endmodule

// File: rtl/tx_mac_control.sv
// GMII transmit MAC: preamble/SFD, frame bytes, zero pad, CRC-32 FCS and
// inter-frame gap, with abort on underrun or oversize.
module tx_mac_control
  import rx_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = GMII_DATA_WIDTH,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int MAX_FRAME_BYTES = 1514,
  parameter int IFG_CYCLES      = 12
) (
  input  logic                  gmii_tx_clk_i,
  input  logic                  gmii_tx_rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  input  logic                  tx_last_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] gmii_tx_data_o,
  output logic                  gmii_tx_en_o,
  output logic                  gmii_tx_er_o,
  output logic                  tx_busy_o,
  output logic                  frame_done_o,
  output logic                  underrun_o
);

  localparam int          IFG_W   = $clog2(IFG_CYCLES + 1);
  localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME_BYTES);
  localparam logic [2:0]  PRE_END = 3'(PREAMBLE_LEN - 1);
  localparam logic [IFG_W-1:0] IFG_END = IFG_W'(IFG_CYCLES);

  tx_state_t             state_reg, state_next;
  logic [2:0]            pre_cnt_reg;
  logic [10:0]           byte_cnt_reg;
  logic [1:0]            fcs_cnt_reg;
  logic [IFG_W-1:0]      ifg_cnt_reg;
  logic [31:0]           crc_reg;
  logic [31:0]           crc_calc;
  logic [31:0]           crc_inv;
  logic [7:0]            crc_feed;
  logic                  crc_en;
  logic [7:0]            fcs_byte;

  logic [DATA_WIDTH-1:0] txd_reg, txd_next;
  logic                  tx_en_reg, tx_en_next;
  logic                  tx_er_reg, tx_er_next;
  logic                  done_reg, done_next;
  logic                  underrun_reg, underrun_next;

  logic                  accept;
  logic                  oversize;

  crc32_byte u_crc32_byte (
    .crc_in  (crc_reg),
    .data    (crc_feed),
    .crc_out (crc_calc)
  );

  assign accept   = (state_reg == ST_DATA) && tx_valid_i;
  assign oversize = (byte_cnt_reg == MAX_CNT);
  assign crc_inv  = ~crc_reg;

  always_comb begin
    case (fcs_cnt_reg)
      2'd0:    fcs_byte = crc_inv[7:0];
      2'd1:    fcs_byte = crc_inv[15:8];
      2'd2:    fcs_byte = crc_inv[23:16];
      default: fcs_byte = crc_inv[31:24];
    endcase
  end

  // State register
  always_ff @(posedge gmii_tx_clk_i or negedge gmii_tx_rst_n) begin
    if (!gmii_tx_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (tx_valid_i) state_next = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (pre_cnt_reg == PRE_END) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (!tx_valid_i) begin
          state_next = ST_ABORT;
        end else if (oversize) begin
          // The offending byte may itself be the last one; nothing left to drain then.
          state_next = tx_last_i ? ST_IFG : ST_ABORT;
        end else if (tx_last_i) begin
          state_next = ((byte_cnt_reg + 11'd1) < MIN_CNT) ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        if ((byte_cnt_reg + 11'd1) >= MIN_CNT) state_next = ST_FCS;
      end
      ST_FCS: begin
        if (fcs_cnt_reg == 2'd3) state_next = ST_IFG;
      end
      ST_ABORT: begin
        if (tx_valid_i && tx_last_i) state_next = ST_IFG;
      end
      ST_IFG: begin
        if (ifg_cnt_reg == IFG_END) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered GMII signals and pulses
  always_comb begin
    txd_next      = '0;
    tx_en_next    = 1'b0;
    tx_er_next    = 1'b0;
    done_next     = 1'b0;
    underrun_next = 1'b0;
    crc_feed      = 8'h00;
    crc_en        = 1'b0;
    tx_ready_o    = 1'b0;
    tx_busy_o     = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (tx_valid_i) begin
          txd_next   = DATA_WIDTH'(PREAMBLE_BYTE);
          tx_en_next = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        tx_en_next = 1'b1;
        txd_next   = (pre_cnt_reg == PRE_END) ? DATA_WIDTH'(SFD_BYTE)
                                              : DATA_WIDTH'(PREAMBLE_BYTE);
      end
      ST_DATA: begin
        tx_ready_o = 1'b1;
        tx_en_next = 1'b1;
        if (accept && !oversize) begin
          txd_next = tx_data_i;
          crc_feed = tx_data_i[7:0];
          crc_en   = 1'b1;
        end else begin
          tx_er_next    = 1'b1;
          underrun_next = 1'b1;
        end
      end
      ST_PAD: begin
        tx_en_next = 1'b1;
        crc_en     = 1'b1;
      end
      ST_FCS: begin
        tx_en_next = 1'b1;
        txd_next   = DATA_WIDTH'(fcs_byte);
        done_next  = (fcs_cnt_reg == 2'd3);
      end
      ST_ABORT: begin
        tx_ready_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge gmii_tx_clk_i or negedge gmii_tx_rst_n) begin
    if (!gmii_tx_rst_n) begin
      pre_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      fcs_cnt_reg  <= '0;
      ifg_cnt_reg  <= '0;
      crc_reg      <= '0;
    end else begin
      pre_cnt_reg <= (state_reg == ST_PREAMBLE) ? pre_cnt_reg + 3'd1 : 3'd0;
      fcs_cnt_reg <= (state_reg == ST_FCS) ? fcs_cnt_reg + 2'd1 : 2'd0;
      ifg_cnt_reg <= (state_reg == ST_IFG) ? ifg_cnt_reg + 1'b1 : '0;
      if (state_reg == ST_IDLE) begin
        byte_cnt_reg <= '0;
        if (tx_valid_i) crc_reg <= CRC32_INIT;
      end else if (crc_en) begin
        byte_cnt_reg <= byte_cnt_reg + 11'd1;
        crc_reg      <= crc_calc;
      end
    end
  end

  always_ff @(posedge gmii_tx_clk_i or negedge gmii_tx_rst_n) begin
    if (!gmii_tx_rst_n) begin
      txd_reg      <= '0;
      tx_en_reg    <= 1'b0;
      tx_er_reg    <= 1'b0;
      done_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      txd_reg      <= txd_next;
      tx_en_reg    <= tx_en_next;
      tx_er_reg    <= tx_er_next;
      done_reg     <= done_next;
      underrun_reg <= underrun_next;
    end
  end

  assign gmii_tx_data_o = txd_reg;
  assign gmii_tx_en_o   = tx_en_reg;
  assign gmii_tx_er_o   = tx_er_reg;
  assign frame_done_o   = done_reg;
  assign underrun_o     = underrun_reg;

endmodule
